// File: rtl/treasure_uart_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | treasure_uart_tx_if : producer-side handshake and UART status bus   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface treasure_uart_tx_if;
  logic [1:0] TREASURE_COLOR;
  logic [1:0] TREASURE_SHAPE;
  logic       VALID;
  logic       READY;
  logic       TX;
  logic       BUSY;
  logic       DONE;

  modport master (
    output TREASURE_COLOR, TREASURE_SHAPE, VALID,
    input  READY, TX, BUSY, DONE
  );

  modport slave (
    input  TREASURE_COLOR, TREASURE_SHAPE, VALID,
    output READY, TX, BUSY, DONE
  );
endinterface
`default_nettype wire

// File: rtl/treasure_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | treasure_uart_tx : sends {4'hA, color, shape} as an 8N1 UART frame  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module treasure_uart_tx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic               CLK,
  input  logic               RESET,
  treasure_uart_tx_if.slave  link
);

  localparam int               CNT_W    = ($clog2(CLKS_PER_BIT) > 16) ? $clog2(CLKS_PER_BIT) : 16;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("treasure_uart_tx: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       data, data_next;
  logic             tx_q, tx_next;
  logic             bit_end;

  assign bit_end = (baud_cnt == BIT_LAST);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      data     <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      data     <= data_next;
      tx_q     <= tx_next;
    end
  end

  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt + CNT_ONE;
    bit_idx_next  = bit_idx;
    data_next     = data;
    case (state)
      S_IDLE: begin
        baud_cnt_next = '0;
        if (link.VALID) begin
          state_next = S_START;
          data_next  = {4'hA, link.TREASURE_COLOR, link.TREASURE_SHAPE};
        end
      end
      S_START: begin
        if (bit_end) begin
          state_next    = S_DATA;
          baud_cnt_next = '0;
          bit_idx_next  = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = S_STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_next    = S_IDLE;
          baud_cnt_next = '0;
        end
      end
      default: begin
        state_next    = S_IDLE;
        baud_cnt_next = '0;
      end
    endcase
  end

  // TX is registered, so its next value follows the state being entered.
  always_comb begin
    case (state_next)
      S_START: tx_next = 1'b0;
      S_DATA:  tx_next = data_next[bit_idx_next];
      default: tx_next = 1'b1;
    endcase
    link.READY = (state == S_IDLE);
    link.BUSY  = (state != S_IDLE);
    link.DONE  = (state == S_STOP) && bit_end;
    link.TX    = tx_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_treasure_uart_tx.sv
`default_nettype none
// Bench for treasure_uart_tx: small-CLKS_PER_BIT instance checked against a
// frame-position model every cycle, plus a default-parameter timing run.
module tb_treasure_uart_tx;
  localparam int CPB   = 4;
  localparam int CPB_B = 5208;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  treasure_uart_tx_if ifa();
  treasure_uart_tx_if ifb();

  treasure_uart_tx #(.CLKS_PER_BIT(CPB)) dut_a (.CLK(CLK), .RESET(RESET), .link(ifa.slave));
  treasure_uart_tx dut_b (.CLK(CLK), .RESET(RESET), .link(ifb.slave));

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: position within the frame (-1 when idle) and the 10 line bits.
  int         pos = -1;
  logic [9:0] frame = '1;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) pos = -1;
    else if (pos >= 0) pos = (pos == 10*CPB-1) ? -1 : pos + 1;
    else if (ifa.VALID) begin
      pos   = 0;
      frame = {1'b1, 4'hA, ifa.TREASURE_COLOR, ifa.TREASURE_SHAPE, 1'b0};
    end
  end

  always @(negedge CLK) begin
    logic [3:0] e;
    e = (pos < 0) ? 4'b1100 : {frame[pos / CPB], 1'b0, 1'b1, (pos == 10*CPB-1)};
    chk("model_a", {ifa.TX, ifa.READY, ifa.BUSY, ifa.DONE}, e);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic drive(input logic [1:0] c, input logic [1:0] s);
    ifa.TREASURE_COLOR = c;
    ifa.TREASURE_SHAPE = s;
    ifa.VALID          = 1'b1;
  endtask

  // Called right after the accept edge; returns at the negedge of the cycle after DONE.
  task automatic observe_frame(input string name, input logic [7:0] b,
                               input int mutate_cyc, input int vraise, input int vdrop);
    logic [9:0] seq;
    int bad[10];
    int dones, busys, rises;
    logic done_last, ready_after, tx_after, prev_ready;
    seq = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) bad[i] = 0;
    dones = 0; busys = 0; rises = 0; prev_ready = 1'b0;
    done_last = 1'b0; ready_after = 1'b0; tx_after = 1'b0;
    for (int cyc = 1; cyc <= 10*CPB+1; cyc++) begin
      @(negedge CLK);
      if (cyc == mutate_cyc) begin
        ifa.TREASURE_COLOR = 2'b00;
        ifa.TREASURE_SHAPE = 2'b00;
      end
      if (cyc == vraise) ifa.VALID = 1'b1;
      if (cyc == vdrop)  ifa.VALID = 1'b0;
      if (ifa.READY === 1'b1 && !prev_ready) rises++;
      prev_ready = ifa.READY;
      if (cyc <= 10*CPB) begin
        if (ifa.TX !== seq[(cyc-1)/CPB]) bad[(cyc-1)/CPB]++;
        if (ifa.BUSY === 1'b1) busys++;
        if (ifa.DONE === 1'b1) dones++;
        if (cyc == 10*CPB) done_last = ifa.DONE;
      end else begin
        ready_after = ifa.READY;
        tx_after    = ifa.TX;
      end
    end
    for (int i = 0; i < 10; i++) chk($sformatf("%s bit%0d error cycles", name, i), bad[i], 0);
    chk({name, " busy cycles"}, busys, 10*CPB);
    chk({name, " done pulses"}, dones, 1);
    chk({name, " done on last stop cycle"}, done_last, 1);
    chk({name, " ready after frame"}, ready_after, 1);
    chk({name, " idle high after frame"}, tx_after, 1);
    chk({name, " ready rises"}, rises, 1);
  endtask

  initial begin
    int bad_b[10];
    int busy_b;
    logic done_b, ready_b;
    logic [9:0] seq_b;

    ifa.VALID = 1'b0; ifa.TREASURE_COLOR = 2'b00; ifa.TREASURE_SHAPE = 2'b00;
    ifb.VALID = 1'b0; ifb.TREASURE_COLOR = 2'b00; ifb.TREASURE_SHAPE = 2'b00;
    repeat (3) @(posedge CLK);
    #2;
    chk("reset state", {ifa.TX, ifa.READY, ifa.BUSY, ifa.DONE}, 4'b1100);

    // Basic frame; accept on the first edge after reset release.
    RESET = 1'b1;
    drive(2'b11, 2'b10);
    @(posedge CLK); #2 ifa.VALID = 1'b0;
    chk("busy after first accept", ifa.BUSY, 1);
    observe_frame("basic", 8'hAE, 0, 0, 0);

    // Inputs cleared mid-frame must not disturb the byte in flight.
    @(posedge CLK); #2 drive(2'b11, 2'b10);
    @(posedge CLK); #2 ifa.VALID = 1'b0;
    observe_frame("stable", 8'hAE, 5, 0, 0);

    // Back-to-back: VALID held across two frames.
    @(posedge CLK); #2 drive(2'b10, 2'b01);
    @(posedge CLK);
    observe_frame("b2b_1", 8'hA9, 0, 0, 0);
    @(posedge CLK); #2 ifa.VALID = 1'b0;
    observe_frame("b2b_2", 8'hA9, 0, 0, 0);

    // VALID raised and dropped while busy is ignored.
    @(posedge CLK); #2 drive(2'b11, 2'b10);
    @(posedge CLK); #2 ifa.VALID = 1'b0;
    observe_frame("ignored", 8'hAE, 0, 10, 30);
    begin
      int busy_after;
      busy_after = 0;
      repeat (12) begin
        @(negedge CLK);
        if (ifa.BUSY !== 1'b0) busy_after++;
      end
      chk("ignored no second frame", busy_after, 0);
    end

    // Reset during data bit 3 of 0xA7 (bit 3 = 0).
    @(posedge CLK); #2 drive(2'b01, 2'b11);
    @(posedge CLK); #2 ifa.VALID = 1'b0;
    repeat (17) @(negedge CLK);
    chk("pre-reset tx data bit3", ifa.TX, 0);
    @(posedge CLK); #2 RESET = 1'b0;
    #1 chk("async reset outputs", {ifa.TX, ifa.READY, ifa.BUSY, ifa.DONE}, 4'b1100);
    repeat (3) @(posedge CLK);
    #2 RESET = 1'b1;
    drive(2'b11, 2'b10);
    @(posedge CLK); #2 ifa.VALID = 1'b0;
    observe_frame("after_reset", 8'hAE, 0, 0, 0);

    // Default CLKS_PER_BIT on the second instance, byte 0xAD.
    @(posedge CLK); #2;
    ifb.TREASURE_COLOR = 2'b11; ifb.TREASURE_SHAPE = 2'b01; ifb.VALID = 1'b1;
    @(posedge CLK); #2 ifb.VALID = 1'b0;
    seq_b = {1'b1, 8'hAD, 1'b0};
    for (int i = 0; i < 10; i++) bad_b[i] = 0;
    busy_b = 0; done_b = 1'b0; ready_b = 1'b0;
    for (int cyc = 1; cyc <= 10*CPB_B+1; cyc++) begin
      @(negedge CLK);
      if (cyc <= 10*CPB_B) begin
        if (ifb.TX !== seq_b[(cyc-1)/CPB_B]) bad_b[(cyc-1)/CPB_B]++;
        if (ifb.BUSY === 1'b1) busy_b++;
        if (cyc == 10*CPB_B) done_b = ifb.DONE;
      end else ready_b = ifb.READY;
    end
    for (int i = 0; i < 10; i++) chk($sformatf("default bit%0d error cycles", i), bad_b[i], 0);
    chk("default frame busy cycles", busy_b, 52080);
    chk("default done on last cycle", done_b, 1);
    chk("default ready after frame", ready_b, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/treasure_uart_tx.md
TREASURE_UART_TX -- requirements
Module: treasure_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 5208, giving clock cycles per serial bit (9600 baud at 50 MHz).
REQ-002 The block SHALL have port CLK, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have port TREASURE_COLOR, input, 2 bits: 0x none, 11 blue, 10 red.
REQ-005 The block SHALL have port TREASURE_SHAPE, input, 2 bits: 00 none, 01 square, 10 triangle, 11 diamond.
REQ-006 The block SHALL have port VALID, input, 1 bit, meaning the producer presents a treasure code for sending.
REQ-007 The block SHALL have port READY, output, 1 bit, meaning the block can accept a code this cycle.
REQ-008 The block SHALL have port TX, output, 1 bit, the UART serial line (idle high).
REQ-009 The block SHALL have port BUSY, output, 1 bit, high while a frame is in progress.
REQ-010 The block SHALL have port DONE, output, 1 bit, a one-cycle pulse at the end of each frame.

Function
REQ-011 The frame byte SHALL be {4'hA, TREASURE_COLOR, TREASURE_SHAPE}, with header 1010 in bits [7:4].
REQ-012 The byte SHALL be captured into an internal register on the cycle VALID=1 and READY=1 (accept cycle).
REQ-013 Input changes after the accept cycle SHALL have no effect on the frame in progress.
REQ-014 The FSM SHALL have states IDLE, START, DATA and STOP, and SHALL leave reset in IDLE.
REQ-015 IDLE -> START SHALL occur on the accept cycle.
REQ-016 START -> DATA SHALL occur after CLKS_PER_BIT cycles.
REQ-017 DATA -> STOP SHALL occur after 8 bits of CLKS_PER_BIT cycles each.
REQ-018 STOP -> IDLE SHALL occur after CLKS_PER_BIT cycles.
REQ-019 TX SHALL be 1 in IDLE, 0 in START, the data bits LSB first in DATA, and 1 in STOP.
REQ-020 TX SHALL be driven from a register, so the first start-bit cycle is the cycle after the accept cycle.
REQ-021 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter running 0..CLKS_PER_BIT-1 that clears at every bit boundary and at accept.
REQ-022 The baud counter SHALL be at least 16 bits wide, and it SHALL not wrap within a bit.
REQ-023 The bit index SHALL be 3 bits, running 0..7, and SHALL be cleared on entry to DATA.
REQ-024 Total frame length SHALL be 10*CLKS_PER_BIT cycles, from the first start-bit cycle through the last stop-bit cycle.
REQ-025 READY SHALL be 1 only in IDLE.
REQ-026 VALID while READY=0 SHALL be ignored; the producer holds VALID until accepted.
REQ-027 BUSY SHALL equal NOT READY.
REQ-028 DONE SHALL be 1 for exactly the last cycle of the stop bit; READY SHALL be 1 on the following cycle.
REQ-029 Back-to-back frames SHALL be supported: if VALID is held, the next accept occurs on the first IDLE cycle, with no gap beyond that one cycle.
REQ-030 CLKS_PER_BIT values below 2 are unsupported, and the block SHALL flag them with a simulation-time error.

Reset
REQ-031 While RESET=0, the block SHALL asynchronously force TX=1, READY=1, BUSY=0, DONE=0, FSM=IDLE, and clear the baud counter, bit index and byte register.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately, with TX high and no DONE pulse.
REQ-033 After reset release, the first accept SHALL be possible on the first rising edge with RESET=1.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-034 The bench SHALL cover a basic frame: color=11, shape=10, VALID pulsed for 1 cycle in IDLE -> byte 0xAE; TX sequence is start 0, then 0,1,1,1,0,1,0,1, then stop 1, each bit 4 cycles; frame length 40 cycles; DONE on cycle 40; READY=1 on cycle 41.
REQ-035 The bench SHALL cover input stability: inputs changed to 00/00 on cycle 5 of the frame -> the frame still transmits 0xAE.
REQ-036 The bench SHALL cover back-to-back frames: VALID held with 10/01 (byte 0xA9) -> two identical frames, with exactly one idle-high cycle between the stop bit and the next start bit.
REQ-037 The bench SHALL cover ignored VALID: VALID asserted while BUSY=1 and dropped before the end of the frame -> no second frame; READY rises once.
REQ-038 The bench SHALL cover reset during DATA: RESET=0 at bit 3 -> TX=1 without waiting for a clock edge, BUSY=0, no DONE; the next frame after release is correct.
REQ-039 The bench SHALL cover the default parameter: CLKS_PER_BIT=5208 with any code -> each bit measures 5208 cycles and the frame measures 52080 cycles.
